axi_sram_slave: RTL and testbench

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_sram_slave_if.sv | 53 +++++
 rtl/axi_sram_slave.sv | 167 ++++++++++++++++
 tb/tb_axi_sram_slave.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_slave_if.sv
// AXI3 bus bundle between the memory master and the SRAM responder.
interface axi_sram_slave_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output wid, wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  wid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 SRAM responder: independent read and write burst FSMs over one word array.
module axi_sram_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_LSB    = 2
) (
  input logic              clk,
  input logic              rst,
  axi_sram_slave_if.slave  s
);
  localparam int unsigned IW = $clog2(DEPTH_WORDS);

  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  logic [31:0] r_mem [DEPTH_WORDS];

  rstate_t     r_rstate;
  logic        r_arready, r_rvalid, r_rlast, r_rsize_err;
  logic [3:0]  r_rid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp, r_rburst;
  logic [7:0]  r_rlen, r_rcnt;
  logic [IW-1:0] r_ridx;

  wstate_t     r_wstate;
  logic        r_awready, r_wready, r_bvalid, r_werr, r_wsize_err, r_wlast_err;
  logic [3:0]  r_bid;
  logic [1:0]  r_bresp, r_wburst;
  logic [7:0]  r_wlen, r_wcnt;
  logic [IW-1:0] r_widx;

  logic [IW-1:0] w_ar_idx, w_aw_idx, w_rd_next, w_wr_next;
  logic          w_ar_size_err, w_aw_size_err, w_wr_en, w_unused;

  assign w_ar_idx      = s.araddr[ADDR_LSB +: IW];
  assign w_aw_idx      = s.awaddr[ADDR_LSB +: IW];
  assign w_ar_size_err = (s.arsize != 3'b010);
  assign w_aw_size_err = (s.awsize != 3'b010);
  // FIXED holds the index; INCR, WRAP and reserved all step and wrap at array end
  assign w_rd_next     = (r_rburst == 2'b00) ? r_ridx : r_ridx + IW'(1);
  assign w_wr_next     = (r_wburst == 2'b00) ? r_widx : r_widx + IW'(1);
  assign w_wr_en       = (r_wstate == W_DATA) && s.wvalid && !r_wsize_err;
  assign w_unused      = ^{s.arlock, s.arcache, s.arprot, s.awlock, s.awcache, s.awprot,
                           s.wid, s.araddr, s.awaddr};

  assign s.arready = r_arready;
  assign s.rvalid  = r_rvalid;
  assign s.rlast   = r_rlast;
  assign s.rid     = r_rid;
  assign s.rdata   = r_rdata;
  assign s.rresp   = r_rresp;
  assign s.awready = r_awready;
  assign s.wready  = r_wready;
  assign s.bvalid  = r_bvalid;
  assign s.bid     = r_bid;
  assign s.bresp   = r_bresp;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (s.wstrb[i]) r_mem[r_widx][8*i +: 8] <= s.wdata[8*i +: 8];
      end
    end
  end

  // Read data is loaded with non-blocking semantics, so a same-cycle write is seen only by later beats
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rstate    <= R_IDLE;
      r_arready   <= 1'b1;
      r_rvalid    <= 1'b0;
      r_rlast     <= 1'b0;
      r_rid       <= '0;
      r_rdata     <= '0;
      r_rresp     <= '0;
      r_rburst    <= '0;
      r_rlen      <= '0;
      r_rcnt      <= '0;
      r_ridx      <= '0;
      r_rsize_err <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: if (s.arvalid) begin
          r_rid       <= s.arid;
          r_ridx      <= w_ar_idx;
          r_rlen      <= s.arlen;
          r_rburst    <= s.arburst;
          r_rsize_err <= w_ar_size_err;
          r_rcnt      <= '0;
          r_rdata     <= w_ar_size_err ? '0 : r_mem[w_ar_idx];
          r_rresp     <= (w_ar_size_err || s.arburst[1]) ? 2'b10 : 2'b00;
          r_rlast     <= (s.arlen == 8'd0);
          r_rvalid    <= 1'b1;
          r_arready   <= 1'b0;
          r_rstate    <= R_DATA;
        end
        R_DATA: if (s.rready) begin
          if (r_rlast) begin
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end else begin
            r_ridx  <= w_rd_next;
            r_rcnt  <= r_rcnt + 8'd1;
            r_rdata <= r_rsize_err ? '0 : r_mem[w_rd_next];
            r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // The burst ends on beat count awlen; wlast only feeds the error status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wstate    <= W_IDLE;
      r_awready   <= 1'b1;
      r_wready    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bid       <= '0;
      r_bresp     <= '0;
      r_wburst    <= '0;
      r_wlen      <= '0;
      r_wcnt      <= '0;
      r_widx      <= '0;
      r_werr      <= 1'b0;
      r_wsize_err <= 1'b0;
      r_wlast_err <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: if (s.awvalid) begin
          r_bid       <= s.awid;
          r_widx      <= w_aw_idx;
          r_wlen      <= s.awlen;
          r_wburst    <= s.awburst;
          r_wsize_err <= w_aw_size_err;
          r_werr      <= w_aw_size_err || s.awburst[1];
          r_wlast_err <= 1'b0;
          r_wcnt      <= '0;
          r_awready   <= 1'b0;
          r_wready    <= 1'b1;
          r_wstate    <= W_DATA;
        end
        W_DATA: if (s.wvalid) begin
          r_widx <= w_wr_next;
          r_wcnt <= r_wcnt + 8'd1;
          if (r_wcnt == r_wlen) begin
            r_wready <= 1'b0;
            r_bvalid <= 1'b1;
            r_bresp  <= (r_werr || r_wlast_err || !s.wlast) ? 2'b10 : 2'b00;
            r_wstate <= W_RESP;
          end else if (s.wlast) begin
            r_wlast_err <= 1'b1;
          end
        end
        W_RESP: if (s.bready) begin
          r_bvalid  <= 1'b0;
          r_awready <= 1'b1;
          r_wstate  <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: writes, bursts, strobes, wrap, errors and mid-burst reset.
module tb_axi_sram_slave;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  axi_sram_slave_if bus();

  axi_sram_slave #(.DEPTH_WORDS(1024), .ADDR_LSB(2)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int cnt = 0;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    while (!bus.awready && cnt < 50) begin @(negedge clk); cnt++; end
    if (cnt >= 50) chk("aw_timeout", 32'(bus.awready), 32'd1);
    @(negedge clk);
    bus.awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int cnt = 0;
    bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
    while (!bus.wready && cnt < 50) begin @(negedge clk); cnt++; end
    if (cnt >= 50) chk("w_timeout", 32'(bus.wready), 32'd1);
    @(negedge clk);
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic b_check(input string tag, input logic [3:0] id, input logic [1:0] resp);
    int cnt = 0;
    bus.bready = 1'b1;
    while (!bus.bvalid && cnt < 50) begin @(negedge clk); cnt++; end
    chk({tag, "_bvalid"}, 32'(bus.bvalid), 32'd1);
    chk({tag, "_bid"}, 32'(bus.bid), 32'(id));
    chk({tag, "_bresp"}, 32'(bus.bresp), 32'(resp));
    @(negedge clk);
    bus.bready = 1'b0;
    chk({tag, "_awready_back"}, 32'(bus.awready), 32'd1);
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int cnt = 0;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
    while (!bus.arready && cnt < 50) begin @(negedge clk); cnt++; end
    if (cnt >= 50) chk("ar_timeout", 32'(bus.arready), 32'd1);
    @(negedge clk);
    bus.arvalid = 1'b0;
  endtask

  task automatic r_beat(input string tag, input logic [31:0] d, input logic [1:0] resp,
                        input logic last, input logic [3:0] id, input bit stall);
    int cnt = 0;
    bus.rready = 1'b0;
    while (!bus.rvalid && cnt < 50) begin @(negedge clk); cnt++; end
    chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'd1);
    chk({tag, "_rdata"}, bus.rdata, d);
    chk({tag, "_rresp"}, 32'(bus.rresp), 32'(resp));
    chk({tag, "_rlast"}, 32'(bus.rlast), 32'(last));
    chk({tag, "_rid"}, 32'(bus.rid), 32'(id));
    if (stall) begin
      @(negedge clk);
      chk({tag, "_stall_rdata"}, bus.rdata, d);
      chk({tag, "_stall_rlast"}, 32'(bus.rlast), 32'(last));
    end
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  initial begin
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'b010; bus.arburst = 2'b01;
    bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'b010; bus.awburst = 2'b01;
    bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_arready", 32'(bus.arready), 32'd1);
    chk("rst_awready", 32'(bus.awready), 32'd1);
    chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
    chk("rst_wready",  32'(bus.wready),  32'd0);
    chk("rst_bvalid",  32'(bus.bvalid),  32'd0);
    chk("rst_rlast",   32'(bus.rlast),   32'd0);
    chk("rst_rdata",   bus.rdata,        32'd0);
    chk("rst_ids",     32'({bus.rid, bus.bid, bus.rresp, bus.bresp}), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_wready", 32'(bus.wready), 32'd0);

    // single write then read
    aw_send(4'd3, 32'h40, 8'd0, 3'b010, 2'b01);
    w_beat(32'hDEADBEEF, 4'hF, 1'b1);
    b_check("single_w", 4'd3, 2'b00);
    ar_send(4'd5, 32'h40, 8'd0, 3'b010, 2'b01);
    chk("single_latency", 32'(bus.rvalid), 32'd1);
    r_beat("single_r", 32'hDEADBEEF, 2'b00, 1'b1, 4'd5, 1'b0);
    chk("single_done_rvalid", 32'(bus.rvalid), 32'd0);
    chk("single_done_arready", 32'(bus.arready), 32'd1);

    // 16-beat INCR with rready stalls
    aw_send(4'd1, 32'h100, 8'd15, 3'b010, 2'b01);
    for (int i = 0; i < 16; i++) w_beat(32'(i), 4'hF, i == 15);
    b_check("incr16_w", 4'd1, 2'b00);
    ar_send(4'd2, 32'h100, 8'd15, 3'b010, 2'b01);
    for (int i = 0; i < 16; i++)
      r_beat($sformatf("incr16_b%0d", i), 32'(i), 2'b00, i == 15, 4'd2, 1'b1);
    chk("incr16_done_rvalid", 32'(bus.rvalid), 32'd0);

    // byte strobes
    aw_send(4'd4, 32'h200, 8'd0, 3'b010, 2'b01);
    w_beat(32'h11223344, 4'hF, 1'b1);
    b_check("strb_w1", 4'd4, 2'b00);
    aw_send(4'd6, 32'h200, 8'd0, 3'b010, 2'b01);
    w_beat(32'hAABBCCDD, 4'b0101, 1'b1);
    b_check("strb_w2", 4'd6, 2'b00);
    ar_send(4'd7, 32'h200, 8'd0, 3'b010, 2'b01);
    r_beat("strb_r", 32'h11BB33DD, 2'b00, 1'b1, 4'd7, 1'b0);

    // array-end wrap: words 1022, 1023, 0, 1
    aw_send(4'd8, 32'hFF8, 8'd3, 3'b010, 2'b01);
    for (int i = 0; i < 4; i++) w_beat(32'hA0 + 32'(i), 4'hF, i == 3);
    b_check("wrap_w", 4'd8, 2'b00);
    ar_send(4'd9, 32'hFF8, 8'd3, 3'b010, 2'b01);
    for (int i = 0; i < 4; i++)
      r_beat($sformatf("wrap_b%0d", i), 32'hA0 + 32'(i), 2'b00, i == 3, 4'd9, 1'b0);
    ar_send(4'd9, 32'h0, 8'd0, 3'b010, 2'b01);
    r_beat("wrap_word0", 32'hA2, 2'b00, 1'b1, 4'd9, 1'b0);

    // FIXED burst lands every beat on one word
    aw_send(4'd10, 32'h300, 8'd3, 3'b010, 2'b00);
    for (int i = 0; i < 4; i++) w_beat(32'(i + 1), 4'hF, i == 3);
    b_check("fixed_w", 4'd10, 2'b00);
    ar_send(4'd11, 32'h300, 8'd0, 3'b010, 2'b01);
    r_beat("fixed_r", 32'd4, 2'b00, 1'b1, 4'd11, 1'b0);

    // unsupported size on read
    ar_send(4'd12, 32'h40, 8'd0, 3'b001, 2'b01);
    r_beat("rsize_err", 32'd0, 2'b10, 1'b1, 4'd12, 1'b0);

    // early wlast: all beats still written, SLVERR response
    aw_send(4'd13, 32'h400, 8'd3, 3'b010, 2'b01);
    for (int i = 0; i < 4; i++) w_beat(32'h50 + 32'(i), 4'hF, i == 1);
    b_check("wlast_err_w", 4'd13, 2'b10);
    ar_send(4'd14, 32'h400, 8'd3, 3'b010, 2'b01);
    for (int i = 0; i < 4; i++)
      r_beat($sformatf("wlast_err_b%0d", i), 32'h50 + 32'(i), 2'b00, i == 3, 4'd14, 1'b0);

    // unsupported size on write is discarded
    aw_send(4'd15, 32'h40, 8'd0, 3'b001, 2'b01);
    w_beat(32'h0, 4'hF, 1'b1);
    b_check("wsize_err_w", 4'd15, 2'b10);
    ar_send(4'd0, 32'h40, 8'd0, 3'b010, 2'b01);
    r_beat("wsize_err_r", 32'hDEADBEEF, 2'b00, 1'b1, 4'd0, 1'b0);

    // WRAP type acts as INCR with SLVERR
    ar_send(4'd1, 32'h100, 8'd1, 3'b010, 2'b10);
    r_beat("wrapburst_b0", 32'd0, 2'b10, 1'b0, 4'd1, 1'b0);
    r_beat("wrapburst_b1", 32'd1, 2'b10, 1'b1, 4'd1, 1'b0);

    // reset during beat 5 of a 16-beat read
    ar_send(4'd3, 32'h100, 8'd15, 3'b010, 2'b01);
    for (int i = 0; i < 5; i++)
      r_beat($sformatf("abort_b%0d", i), 32'(i), 2'b00, 1'b0, 4'd3, 1'b0);
    rst = 1'b0;
    #1;
    chk("abort_rvalid", 32'(bus.rvalid), 32'd0);
    chk("abort_arready", 32'(bus.arready), 32'd1);
    chk("abort_rdata_rid", {bus.rdata[27:0], bus.rid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_post_rvalid", 32'(bus.rvalid), 32'd0);
    ar_send(4'd6, 32'h40, 8'd0, 3'b010, 2'b01);
    r_beat("abort_next", 32'hDEADBEEF, 2'b00, 1'b1, 4'd6, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
